fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. It consumes the hazard unit's `pc_ld`, `IF_ID_write` and `flush` controls. It owns the PC, drives the instruction-memory address, and computes the jump target from the instruction held in IF/ID. It also keeps saturating performance counters for stall and flush events and latches a sticky flag when the control inputs arrive in an illegal combination.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 69 ++++++
 tb/tb_fetch_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard controls, instruction-memory port and IF/ID register outputs of the fetch stage.
interface fetch_stage_if;
    logic        pc_ld;
    logic        IF_ID_write;
    logic        flush;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;
    modport master (
        output pc_ld, IF_ID_write, flush, jump, branch_target, inst_data,
        input  inst_addr, IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid
    );
    modport slave (
        input  pc_ld, IF_ID_write, flush, jump, branch_target, inst_data,
        output inst_addr, IF_ID_inst, IF_ID_pc_plus4, IF_ID_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID pipeline register, redirect on flush, stall/flush counters and control-protocol checker.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.slave     bus,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             protocol_err
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_BUBBLE} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect;
    logic        stall;
    logic        take_flush;
    logic        load;
    always_comb begin
        pc_plus4    = pc + 32'd4;
        jump_target = {if_pc4[31:28], if_inst[25:0], 2'b00};
        redirect    = bus.jump ? jump_target : bus.branch_target;
        stall       = !bus.pc_ld;
        // a flush during a stall carries a stale comparator result, so it is dropped
        take_flush  = bus.pc_ld && bus.flush;
        load        = bus.IF_ID_write && !take_flush;
    end
    assign bus.inst_addr      = pc;
    assign bus.IF_ID_inst     = if_inst;
    assign bus.IF_ID_pc_plus4 = if_pc4;
    assign bus.IF_ID_valid    = if_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RESET;
            pc           <= RESET_PC;
            if_inst      <= '0;
            if_pc4       <= '0;
            if_valid     <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
            protocol_err <= 1'b0;
        end else begin
            pc <= stall ? pc : take_flush ? redirect : pc_plus4;
            if (take_flush) begin
                if_inst  <= '0;
                if_pc4   <= '0;
                if_valid <= 1'b0;
            end else if (load) begin
                if_inst  <= bus.inst_data;
                if_pc4   <= pc_plus4;
                if_valid <= 1'b1;
            end
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (take_flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
            // advancing the PC without capturing the fetched word loses an instruction
            if (!stall && !bus.flush && !bus.IF_ID_write)
                protocol_err <= 1'b1;
            state <= take_flush ? S_BUBBLE : (state == S_BUBBLE && !load) ? S_BUBBLE : S_RUN;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with hand-computed expectations for fetch_stage.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] stall_cycles;
    logic [1:0] flush_count;
    logic protocol_err;
    int checks = 0;
    int errors = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // word at 0x4000_0004 is a J with target field 0x40
    assign bus.inst_data = (bus.inst_addr == 32'h4000_0004) ? 32'h0800_0040 : tag(bus.inst_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string name, input logic [31:0] addr, input logic [31:0] inst,
                              input logic [31:0] pc4, input logic valid);
        check({name, ".addr"}, bus.inst_addr, addr);
        check({name, ".inst"}, bus.IF_ID_inst, inst);
        check({name, ".pc4"}, bus.IF_ID_pc_plus4, pc4);
        check({name, ".valid"}, {31'd0, bus.IF_ID_valid}, {31'd0, valid});
    endtask

    task automatic check_cnt(input string name, input int stalls, input int flushes, input logic err);
        check({name, ".stall"}, {30'd0, stall_cycles}, stalls);
        check({name, ".flush"}, {30'd0, flush_count}, flushes);
        check({name, ".perr"}, {31'd0, protocol_err}, {31'd0, err});
    endtask

    initial begin
        bus.pc_ld = 1'b1;
        bus.IF_ID_write = 1'b1;
        bus.flush = 1'b0;
        bus.jump = 1'b0;
        bus.branch_target = 32'h0;
        tick();
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("reset", 0, 0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_ifid("run", 4 * i, tag(4 * (i - 1)), 4 * i, 1'b1);
        end
        check_cnt("run", 0, 0, 1'b0);
        bus.pc_ld = 1'b0;
        bus.IF_ID_write = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            check_ifid("stall", 32'h10, tag(32'h0C), 32'h10, 1'b1);
            check("stall.cnt", {30'd0, stall_cycles}, i);
        end
        bus.pc_ld = 1'b1;
        bus.IF_ID_write = 1'b1;
        tick();
        check_ifid("resume", 32'h14, tag(32'h10), 32'h14, 1'b1);
        bus.flush = 1'b1;
        bus.branch_target = 32'h100;
        tick();
        check_ifid("branch", 32'h100, 32'h0, 32'h0, 1'b0);
        check_cnt("branch", 2, 1, 1'b0);
        bus.flush = 1'b0;
        tick();
        check_ifid("post_branch", 32'h104, tag(32'h100), 32'h104, 1'b1);
        bus.flush = 1'b1;
        bus.branch_target = 32'h4000_0004;
        tick();
        bus.flush = 1'b0;
        tick();
        check_ifid("j_setup", 32'h4000_0008, 32'h0800_0040, 32'h4000_0008, 1'b1);
        bus.flush = 1'b1;
        bus.jump = 1'b1;
        bus.branch_target = 32'h300;
        tick();
        check_ifid("jump", 32'h4000_0100, 32'h0, 32'h0, 1'b0);
        check("jump.fcnt", {30'd0, flush_count}, 3);
        bus.flush = 1'b0;
        bus.jump = 1'b0;
        tick();
        check_ifid("post_jump", 32'h4000_0104, tag(32'h4000_0100), 32'h4000_0104, 1'b1);
        bus.pc_ld = 1'b0;
        bus.IF_ID_write = 1'b0;
        bus.flush = 1'b1;
        bus.branch_target = 32'h200;
        tick();
        check_ifid("flush_stall", 32'h4000_0104, tag(32'h4000_0100), 32'h4000_0104, 1'b1);
        check_cnt("flush_stall", 3, 3, 1'b0);
        bus.pc_ld = 1'b1;
        bus.IF_ID_write = 1'b1;
        tick();
        check_ifid("flush_late", 32'h200, 32'h0, 32'h0, 1'b0);
        check_cnt("flush_sat", 3, 3, 1'b0);
        bus.flush = 1'b0;
        bus.pc_ld = 1'b0;
        bus.IF_ID_write = 1'b0;
        tick();
        check("stall_sat.addr", bus.inst_addr, 32'h200);
        check("stall_sat.cnt", {30'd0, stall_cycles}, 3);
        bus.pc_ld = 1'b1;
        tick();
        check_ifid("perr", 32'h204, 32'h0, 32'h0, 1'b0);
        check("perr.set", {31'd0, protocol_err}, 1);
        bus.IF_ID_write = 1'b1;
        tick();
        check_ifid("perr_hold", 32'h208, tag(32'h204), 32'h208, 1'b1);
        check("perr.sticky", {31'd0, protocol_err}, 1);
        bus.flush = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        tick();
        check_ifid("wrap", 32'h0, tag(32'hFFFF_FFFC), 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("async_rst", 0, 0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_ifid("restart", 32'h4, tag(32'h0), 32'h4, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
